psum_accum_bank: RTL and testbench

//  Generalised partial-sum buffer for the eyeriss PE array. Holds NUM_LINES parallel line RAMs of

---
 rtl/psum_accum_bank_pkg.sv | 15 +
 rtl/psum_sdp_ram.sv | 23 ++
 rtl/psum_accum_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_psum_accum_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_bank_pkg.sv
// Shared defaults and types for the partial-sum accumulation bank.
package psum_accum_bank_pkg;

  localparam int PSUM_NUM_LINES = 3;
  localparam int PSUM_LANES     = 4;
  localparam int PSUM_LANE_W    = 21;
  localparam int PSUM_ADDR_W    = 9;
  localparam int IMG_W          = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/psum_sdp_ram.sv
// Simple dual-port line RAM: one write port, one registered read port (1-cycle latency).
module psum_sdp_ram #(
  parameter int WIDTH  = 84,
  parameter int ADDR_W = 9
) (
  input  logic              s_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // NOTE: no reset on the array or read register so the tools can map this onto block RAM.
  // A same-cycle read of the written address returns the old word.
  always_ff @(posedge s_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/psum_accum_bank.sv
// Partial-sum bank: NUM_LINES parallel line RAMs with plain/accumulating writes,
// all-lines or serial one-line reads, and a hardware clear sweep.
module psum_accum_bank
  import psum_accum_bank_pkg::*;
#(
  parameter  int NUM_LINES = PSUM_NUM_LINES,
  parameter  int LANES     = PSUM_LANES,
  parameter  int LANE_W    = PSUM_LANE_W,
  parameter  int ADDR_W    = PSUM_ADDR_W,
  localparam int DATA_W    = LANES * LANE_W,
  localparam int BUS_W     = NUM_LINES * DATA_W,
  localparam int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              cfg_valid,
  input  logic [IMG_W-1:0]  cfg_img_size,
  input  logic              cfg_acc_en,
  input  logic              clr_start,
  output logic              busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic              rd_mode,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [BUS_W-1:0]  rd_data,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic [LINE_W-1:0] rd1_line
);

  function automatic logic [LANE_W-1:0] sat_add(input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
    logic signed [LANE_W:0] s;
    s = $signed({a[LANE_W-1], a}) + $signed({b[LANE_W-1], b});
    if (s[LANE_W] != s[LANE_W-1])
      sat_add = s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    else
      sat_add = s[LANE_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic               acc_en_q;
  logic [IMG_W-1:0]   img_size_q;
  logic               wr_fire, rd_fire;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      acc_en_q   <= 1'b0;
      img_size_q <= '0;
    end else if (cfg_valid) begin
      acc_en_q   <= cfg_acc_en;
      img_size_q <= cfg_img_size;
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        rd_ready = ~acc_en_q;
        if (clr_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (&clr_cnt_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_fire = wr_valid & wr_ready;
  assign rd_fire = rd_req & rd_ready;

  // Write pipelines: plain (one stage) and read-modify-write (s1 RAM data, s2 add/write, s3 last write).
  logic               p_valid_q, s1_valid_q, s2_valid_q, s3_valid_q;
  logic [ADDR_W-1:0]  p_addr_q, s1_addr_q, s2_addr_q, s3_addr_q;
  logic [BUS_W-1:0]   p_data_q, s1_op_q, s2_op_q, s2_base_q, s3_data_q;
  logic [BUS_W-1:0]   s2_sum, fwd_base, ram_rdata, ram_wdata;
  logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
  logic               ram_we;

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      p_valid_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      p_valid_q  <= wr_fire & ~acc_en_q;
      s1_valid_q <= wr_fire & acc_en_q;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q & (state_q != ST_CLEAR);
    end
  end

  always_ff @(posedge s_clk) begin
    p_addr_q  <= wr_addr;
    p_data_q  <= wr_data;
    s1_addr_q <= wr_addr;
    s1_op_q   <= wr_data;
    s2_addr_q <= s1_addr_q;
    s2_op_q   <= s1_op_q;
    s2_base_q <= fwd_base;
    s3_addr_q <= s2_addr_q;
    s3_data_q <= s2_sum;
  end

  // RAM data is stale for an address still being summed (s2) or written last cycle (s3).
  always_comb begin
    fwd_base = ram_rdata;
    if (s2_valid_q && s2_addr_q == s1_addr_q)      fwd_base = s2_sum;
    else if (s3_valid_q && s3_addr_q == s1_addr_q) fwd_base = s3_data_q;
  end

  always_comb begin
    s2_sum = '0;
    for (int l = 0; l < NUM_LINES; l++)
      for (int k = 0; k < LANES; k++)
        s2_sum[l*DATA_W + k*LANE_W +: LANE_W] =
          sat_add(s2_base_q[l*DATA_W + k*LANE_W +: LANE_W], s2_op_q[l*DATA_W + k*LANE_W +: LANE_W]);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = p_addr_q;
    ram_wdata = p_data_q;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
    end else if (s2_valid_q) begin
      ram_we    = 1'b1;
      ram_waddr = s2_addr_q;
      ram_wdata = s2_sum;
    end else if (p_valid_q) begin
      ram_we    = 1'b1;
    end
  end

  assign ram_raddr = acc_en_q ? wr_addr : rd_addr;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    psum_sdp_ram #(.WIDTH(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .s_clk (s_clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata[g*DATA_W +: DATA_W]),
      .raddr (ram_raddr),
      .rdata (ram_rdata[g*DATA_W +: DATA_W])
    );
  end

  // Serial sequencer: LIMIT reads per line, then advance to the next line.
  logic [LINE_W-1:0] sel_q, rs_line1_q, rs_line2_q;
  logic [IMG_W-1:0]  cnt_q, limit;
  logic              ra_v1_q, rs_v1_q, rs_v2_q;
  logic [DATA_W-1:0] sel_word, rs_data2_q;

  assign limit = (img_size_q < 16'd3) ? 16'd1 : img_size_q - 16'd2;

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!rd_mode) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else if (rd_fire) begin
      if (cnt_q == limit - 16'd1) begin
        cnt_q <= '0;
        sel_q <= (sel_q == LINE_W'(NUM_LINES - 1)) ? '0 : sel_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    sel_word = ram_rdata[0 +: DATA_W];
    for (int i = 0; i < NUM_LINES; i++)
      if (rs_line1_q == LINE_W'(i)) sel_word = ram_rdata[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      ra_v1_q    <= 1'b0;
      rs_v1_q    <= 1'b0;
      rs_v2_q    <= 1'b0;
      rs_line1_q <= '0;
      rs_line2_q <= '0;
      rs_data2_q <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd1_valid  <= 1'b0;
      rd1_data   <= '0;
      rd1_line   <= '0;
    end else begin
      ra_v1_q    <= rd_fire & ~rd_mode;
      rs_v1_q    <= rd_fire & rd_mode;
      rs_line1_q <= sel_q;
      rs_v2_q    <= rs_v1_q;
      rd_valid   <= ra_v1_q;
      rd1_valid  <= rs_v2_q;
      if (ra_v1_q) rd_data <= ram_rdata;
      if (rs_v1_q) begin
        rs_data2_q <= sel_word;
        rs_line2_q <= rs_line1_q;
      end
      if (rs_v2_q) begin
        rd1_data <= rs_data2_q;
        rd1_line <= rs_line2_q;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_bank.sv
// Scoreboard bench for psum_accum_bank: stimulus pushes expected reads, a monitor pops and compares.
module tb_psum_accum_bank;

  localparam int NL  = 3;
  localparam int LN  = 4;
  localparam int LW  = 21;
  localparam int AW  = 9;
  localparam int DW  = LN * LW;
  localparam int BW  = NL * DW;
  localparam int LIW = 2;

  logic           s_clk = 1'b0;
  logic           s_rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [15:0]    cfg_img_size = '0;
  logic           cfg_acc_en = 1'b0;
  logic           clr_start = 1'b0;
  logic           busy;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [AW-1:0]  wr_addr = '0;
  logic [BW-1:0]  wr_data = '0;
  logic           rd_mode = 1'b0;
  logic           rd_req = 1'b0;
  logic           rd_ready;
  logic [AW-1:0]  rd_addr = '0;
  logic           rd_valid;
  logic [BW-1:0]  rd_data;
  logic           rd1_valid;
  logic [DW-1:0]  rd1_data;
  logic [LIW-1:0] rd1_line;

  psum_accum_bank #(.NUM_LINES(NL), .LANES(LN), .LANE_W(LW), .ADDR_W(AW)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .cfg_valid(cfg_valid), .cfg_img_size(cfg_img_size),
    .cfg_acc_en(cfg_acc_en), .clr_start(clr_start), .busy(busy), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .rd_mode(rd_mode),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd1_valid(rd1_valid), .rd1_data(rd1_data), .rd1_line(rd1_line)
  );

  always #5 s_clk = ~s_clk;

  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [BW-1:0] data;
    int            line;
    int            at;
  } exp_t;

  exp_t q_all[$];
  exp_t q_ser[$];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] lane(input logic [BW-1:0] bus, input int l, input int k,
                                         input int v);
    logic [BW-1:0] b;
    b = bus;
    b[l*DW + k*LW +: LW] = LW'(v);
    return b;
  endfunction

  // Monitor: every valid output must match the oldest expectation, at its expected cycle.
  always @(negedge s_clk) begin : monitor
    exp_t e;
    if (!s_rst) begin
      if (rd_valid) begin
        if (q_all.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 at cycle %0d required no read pending", cyc);
        end else begin
          e = q_all.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_latency", BW'(cyc), BW'(e.at));
        end
      end
      if (rd1_valid) begin
        if (q_ser.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd1_valid_unexpected: got rd1_valid=1 at cycle %0d required no read pending", cyc);
        end else begin
          e = q_ser.pop_front();
          check("rd1_data", BW'(rd1_data), e.data);
          check("rd1_line", BW'(rd1_line), BW'(e.line));
          check("rd1_latency", BW'(cyc), BW'(e.at));
        end
      end
    end
  end

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic cfg(input int img, input logic acc);
    cfg_valid    = 1'b1;
    cfg_img_size = 16'(img);
    cfg_acc_en   = acc;
    tick();
    cfg_valid = 1'b0;
    tick();
  endtask

  task automatic wr(input int addr, input logic [BW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_all(input int addr, input logic [BW-1:0] e);
    exp_t x;
    check("rd_ready_mode0", BW'(rd_ready), BW'(1));
    rd_req  = 1'b1;
    rd_mode = 1'b0;
    rd_addr = AW'(addr);
    x.data = e; x.line = 0; x.at = cyc + 2;
    q_all.push_back(x);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_ser(input int addr, input logic [DW-1:0] e, input int line);
    exp_t x;
    rd_req  = 1'b1;
    rd_mode = 1'b1;
    rd_addr = AW'(addr);
    x.data = BW'(e); x.line = line; x.at = cyc + 3;
    q_ser.push_back(x);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_clear();
    int n;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      if (n == 10) check("wr_ready_in_clear", BW'(wr_ready), BW'(0));
      tick();
    end
    check("clear_busy_cycles", BW'(n), BW'(512));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [BW-1:0] w5, wa, wb, acc3, one, w7;
    repeat (3) tick();
    check("rst_busy",      BW'(busy),      BW'(0));
    check("rst_rd_valid",  BW'(rd_valid),  BW'(0));
    check("rst_rd1_valid", BW'(rd1_valid), BW'(0));
    check("rst_rd_data",   rd_data,        BW'(0));
    check("rst_rd1_data",  BW'(rd1_data),  BW'(0));
    s_rst = 1'b0;
    tick();

    // Clear sweep, then edge addresses must read zero.
    do_clear();
    rd_all(0, '0);
    rd_all(511, '0);

    // Plain write and readback.
    w5 = lane(lane(lane('0, 1, 0, 7), 0, 3, -3), 2, 1, 12345);
    wr(5, w5);
    tick();
    rd_all(5, w5);

    // Read in the cycle the RAM is written returns the old word.
    wa = lane('0, 0, 0, 111);
    wb = lane('0, 0, 0, 222);
    wr(6, wa);
    tick();
    wr(6, wb);
    rd_all(6, wa);
    tick();
    rd_all(6, wb);

    // Accumulating writes with forwarding and saturation.
    cfg(0, 1'b1);
    check("rd_ready_acc", BW'(rd_ready), BW'(0));
    do_clear();
    acc3 = lane(lane('0, 0, 0, 100), 2, 1, -7);
    one  = lane('0, 0, 0, 1);
    wr(3, acc3);
    wr(3, acc3);
    wr(3, acc3);
    wr(20, one);
    wr(20, one);
    wr(21, one);
    wr(20, one);
    wr(9,  lane('0, 0, 2, 1048575));
    wr(9,  lane('0, 0, 2, 5));
    wr(10, lane('0, 0, 2, -1048576));
    wr(10, lane('0, 0, 2, -1));
    repeat (4) tick();
    cfg(5, 1'b0);
    rd_all(3,  lane(lane('0, 0, 0, 300), 2, 1, -21));
    rd_all(20, lane('0, 0, 0, 3));
    rd_all(21, lane('0, 0, 0, 1));
    rd_all(9,  lane('0, 0, 2, 1048575));
    rd_all(10, lane('0, 0, 2, -1048576));

    // Serial reads, img_size=5 -> three reads per line.
    w7 = lane(lane(lane(lane('0, 0, 0, 11), 1, 1, 22), 2, 3, 33), 1, 0, 44);
    wr(7, w7);
    tick();
    for (int i = 0; i < 9; i++) rd_ser(7, w7[(i/3)*DW +: DW], i/3);
    rd_mode = 1'b0;
    tick();
    rd_ser(7, w7[0 +: DW], 0);
    rd_mode = 1'b0;

    // img_size below 3 -> every read advances the line.
    cfg(2, 1'b0);
    rd_ser(7, w7[0 +: DW], 0);
    rd_ser(7, w7[DW +: DW], 1);
    rd_mode = 1'b0;

    repeat (6) tick();
    check("sb_all_drained", BW'(q_all.size()), BW'(0));
    check("sb_ser_drained", BW'(q_ser.size()), BW'(0));

    // Async reset in the middle of a clear sweep.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    check("mid_clear_busy", BW'(busy), BW'(1));
    #2 s_rst = 1'b1;
    #1;
    check("rst_mid_busy",      BW'(busy),      BW'(0));
    check("rst_mid_rd_data",   rd_data,        BW'(0));
    check("rst_mid_rd1_data",  BW'(rd1_data),  BW'(0));
    check("rst_mid_rd1_valid", BW'(rd1_valid), BW'(0));
    tick();
    s_rst = 1'b0;
    tick();
    check("post_rst_wr_ready", BW'(wr_ready), BW'(1));
    check("post_rst_busy",     BW'(busy),     BW'(0));
    rd_all(7, '0);
    repeat (4) tick();
    check("sb_final_drained", BW'(q_all.size()), BW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
